// File: rtl/tape_encoder_if.sv
// tape_encoder_if: byte stream handshake into the tape encoder.
//   din        data byte
//   din_valid  din holds a valid byte
//   din_last   din is the final data byte of the file
//   din_ready  encoder accepts din this cycle
// master = byte source, slave = tape_encoder.
interface tape_encoder_if;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;

  modport master (output din, output din_valid, output din_last, input din_ready);
  modport slave  (input din, input din_valid, input din_last, output din_ready);
endinterface

// File: rtl/tape_encoder.sv
// tape_encoder: Radio-86RK/Apogee cassette signal generator.
// Takes a byte stream and emits a Manchester-coded tape level: a leader of
// LEADER_LEN 0x00 bytes, SYNC_BYTE, the data bytes, then TRAIL_LEN 0x00
// bytes. Each bit (MSB first) is two half-cells of HALF_BIT clocks: first
// half = ~bit, second half = bit. One byte of buffering (hold register)
// sits in front of the shifter.
// Ports:
//   clk_sys   system clock, posedge
//   RESET     synchronous, active-low reset
//   start     one-cycle pulse, starts a transmission when idle
//   din_if    byte stream handshake (slave modport)
//   tape_out  encoded tape level (registered)
//   busy      high from accepted start until back in IDLE
//   underrun  sticky: a byte was needed while the hold register was empty
module tape_encoder #(
  parameter int         HALF_BIT   = 1728,
  parameter int         LEADER_LEN = 256,
  parameter int         TRAIL_LEN  = 2,
  parameter logic [7:0] SYNC_BYTE  = 8'hE6
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 start,
  tape_encoder_if.slave        din_if,
  output logic                 tape_out,
  output logic                 busy,
  output logic                 underrun
);

  localparam int CNT_W = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADER,
    S_SYNC,
    S_DATA,
    S_TRAIL
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;          // clocks within a half-cell
  logic [3:0]         half_q, half_d;        // half-cell index within byte
  logic [8:0]         bytes_q, bytes_d;      // leader/trailer bytes left
  logic [7:0]         shift_q, shift_d;      // byte being sent
  logic [7:0]         hold_q, hold_d;
  logic               hold_last_q, hold_last_d;
  logic               hold_vld_q, hold_vld_d;
  logic               last_acc_q, last_acc_d;   // final byte already taken in
  logic               last_sent_q, last_sent_d; // shifter holds the final byte
  logic               stall_q, stall_d;         // frozen on underrun
  logic               tape_out_q, tape_out_d;
  logic               busy_q, busy_d;
  logic               underrun_q, underrun_d;
  logic               din_ready_q, din_ready_d;

  logic               accept;
  logic               taken;   // accepted byte went straight into the shifter
  logic               wrap;

  // Tape level of half-cell h of byte b: even half = ~bit, odd half = bit.
  function automatic logic cell_level(input logic [7:0] b, input logic [3:0] h);
    logic [2:0] idx;
    idx = ~h[3:1];
    return h[0] ? b[idx] : ~b[idx];
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    bytes_d     = bytes_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_vld_d  = hold_vld_q;
    last_acc_d  = last_acc_q;
    last_sent_d = last_sent_q;
    stall_d     = stall_q;
    tape_out_d  = tape_out_q;
    busy_d      = busy_q;
    underrun_d  = underrun_q;
    taken       = 1'b0;
    accept      = din_if.din_valid && din_ready_q;
    wrap        = (cnt_q == CNT_W'(HALF_BIT - 1));

    if (accept && din_if.din_last) last_acc_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tape_out_d = 1'b0;
        if (start) begin
          state_d     = S_LEADER;
          busy_d      = 1'b1;
          underrun_d  = 1'b0;
          shift_d     = 8'h00;
          bytes_d     = 9'(LEADER_LEN);
          cnt_d       = '0;
          half_d      = '0;
          stall_d     = 1'b0;
          hold_vld_d  = 1'b0;
          last_acc_d  = 1'b0;
          last_sent_d = 1'b0;
          tape_out_d  = cell_level(8'h00, 4'd0);
        end
      end
      default: begin
        if (stall_q) begin
          // Counter and level are frozen; the late byte restarts encoding
          // directly, without passing through the hold register.
          if (accept) begin
            shift_d     = din_if.din;
            last_sent_d = din_if.din_last;
            taken       = 1'b1;
            stall_d     = 1'b0;
            cnt_d       = '0;
            half_d      = '0;
            tape_out_d  = cell_level(din_if.din, 4'd0);
          end
        end else if (!wrap) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d  = '0;
          half_d = half_q + 1'b1;
          if (half_q != 4'd15) begin
            tape_out_d = cell_level(shift_q, half_q + 1'b1);
          end else begin
            // Byte boundary: choose the next byte.
            case (state_q)
              S_LEADER: begin
                if (bytes_q == 9'd1) begin
                  state_d = S_SYNC;
                  shift_d = SYNC_BYTE;
                end else begin
                  bytes_d = bytes_q - 1'b1;
                end
              end
              S_TRAIL: begin
                if (bytes_q == 9'd1) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                end else begin
                  bytes_d = bytes_q - 1'b1;
                end
              end
              default: begin
                if (state_q == S_DATA && last_sent_q) begin
                  state_d = S_TRAIL;
                  bytes_d = 9'(TRAIL_LEN);
                  shift_d = 8'h00;
                end else begin
                  state_d = S_DATA;
                  if (hold_vld_q) begin
                    shift_d     = hold_q;
                    last_sent_d = hold_last_q;
                    hold_vld_d  = 1'b0;
                  end else if (accept) begin
                    // Byte arriving exactly at the boundary is used at once.
                    shift_d     = din_if.din;
                    last_sent_d = din_if.din_last;
                    taken       = 1'b1;
                  end else begin
                    stall_d    = 1'b1;
                    underrun_d = 1'b1;
                  end
                end
              end
            endcase
            if (stall_d)                tape_out_d = tape_out_q;
            else if (state_d == S_IDLE) tape_out_d = 1'b0;
            else                        tape_out_d = cell_level(shift_d, 4'd0);
          end
        end
      end
    endcase

    if (accept && !taken) begin
      hold_d      = din_if.din;
      hold_last_d = din_if.din_last;
      hold_vld_d  = 1'b1;
    end

    din_ready_d = !hold_vld_d && !last_acc_d &&
                  (state_d == S_SYNC || state_d == S_DATA);
  end

  always_ff @(posedge clk_sys) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      half_q      <= '0;
      bytes_q     <= '0;
      hold_vld_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      last_sent_q <= 1'b0;
      stall_q     <= 1'b0;
      tape_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      din_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      bytes_q     <= bytes_d;
      hold_vld_q  <= hold_vld_d;
      last_acc_q  <= last_acc_d;
      last_sent_q <= last_sent_d;
      stall_q     <= stall_d;
      tape_out_q  <= tape_out_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      din_ready_q <= din_ready_d;
    end
    shift_q     <= shift_d;
    hold_q      <= hold_d;
    hold_last_q <= hold_last_d;
  end

  assign din_if.din_ready = din_ready_q;
  assign tape_out         = tape_out_q;
  assign busy             = busy_q;
  assign underrun         = underrun_q;

endmodule

// File: tb/tb_tape_encoder.sv
module tb_tape_encoder;

  localparam int HB   = 4;
  localparam int LL   = 2;
  localparam int TL   = 1;
  localparam int BCYC = 16 * HB;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b0;
  logic start   = 1'b0;
  logic tape_out, busy, underrun;

  tape_encoder_if bus();

  tape_encoder #(
    .HALF_BIT   (HB),
    .LEADER_LEN (LL),
    .TRAIL_LEN  (TL),
    .SYNC_BYTE  (8'hE6)
  ) dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .start    (start),
    .din_if   (bus),
    .tape_out (tape_out),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int busy_total = 0;
  int e0;
  logic [7:0] exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(negedge clk_sys) if (busy) busy_total++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk_sys);
  endtask

  // Pulse start at a negedge; returns at the first negedge after the start edge.
  task automatic do_start();
    start = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < LL; i++) exp_q.push_back(8'h00);
    exp_q.push_back(8'hE6);
    @(negedge clk_sys);
    start = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic last, output int acc);
    int k;
    exp_q.push_back(b);
    if (last) for (int i = 0; i < TL; i++) exp_q.push_back(8'h00);
    bus.din       = b;
    bus.din_last  = last;
    bus.din_valid = 1'b1;
    acc = -1;
    for (k = 0; k < 3000; k++) begin
      if (bus.din_ready) break;
      @(negedge clk_sys);
    end
    if (k == 3000) chk("accept_timeout", 32'd0, 32'd1);
    else acc = cyc + 1;
    @(negedge clk_sys);
    bus.din_valid = 1'b0;
  endtask

  // Reads the tape waveform half-cell by half-cell and compares each byte
  // against the scoreboard. The last half-cell of byte stall_byte is
  // expected to be stretched by stall_len clocks.
  task automatic decode_stream(input int nbytes, input int stall_byte, input int stall_len);
    logic [7:0] val, ex;
    logic       lvl, first;
    int         bad, len;
    for (int bi = 0; bi < nbytes; bi++) begin
      val = '0; bad = 0; first = 1'b0;
      for (int h = 0; h < 16; h++) begin
        len = HB + ((bi == stall_byte && h == 15) ? stall_len : 0);
        lvl = tape_out;
        for (int c = 0; c < len; c++) begin
          if (tape_out !== lvl) bad++;
          @(negedge clk_sys);
        end
        if (h % 2 == 0) first = lvl;
        else begin
          val = {val[6:0], lvl};
          if (lvl === first) bad++;
        end
      end
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
        ex = 8'h00;
      end else ex = exp_q.pop_front();
      chk($sformatf("byte%0d", bi), 32'(val), 32'(ex));
      chk($sformatf("cells%0d", bi), 32'(bad), 32'd0);
    end
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_tape", 32'(tape_out), 32'd0);
  endtask

  initial begin
    int a0, a1, a2, base, cnt;
    bus.din = 8'h00; bus.din_valid = 1'b0; bus.din_last = 1'b0;

    repeat (3) @(negedge clk_sys);
    chk("rst_tape", 32'(tape_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.din_ready), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    RESET = 1'b1;
    repeat (3) @(negedge clk_sys);

    // single byte presented during sync
    base = busy_total;
    do_start();
    fork
      decode_stream(5, -1, 0);
      begin wait_cyc(e0 + LL * BCYC); put_byte(8'hA5, 1'b1, a0); end
    join
    chk("A_busy_len", 32'(busy_total - base), 32'd320);
    chk("A_underrun", 32'(underrun), 32'd0);
    repeat (5) @(negedge clk_sys);

    // back-to-back bytes, din_valid held high
    base = busy_total;
    do_start();
    fork
      decode_stream(7, -1, 0);
      begin
        put_byte(8'h00, 1'b0, a0);
        put_byte(8'hFF, 1'b0, a1);
        put_byte(8'h55, 1'b1, a2);
        cnt = 0;
        for (int k = 0; k < 1000 && busy; k++) begin
          if (bus.din_ready) cnt++;
          @(negedge clk_sys);
        end
        chk("B_ready_after_last", 32'(cnt), 32'd0);
      end
    join
    chk("B_acc0", 32'(a0), 32'(e0 + LL * BCYC + 1));
    chk("B_acc1", 32'(a1), 32'(e0 + (LL + 1) * BCYC + 1));
    chk("B_acc2", 32'(a2), 32'(e0 + (LL + 2) * BCYC + 1));
    chk("B_busy_len", 32'(busy_total - base), 32'(7 * BCYC));
    repeat (5) @(negedge clk_sys);

    // underrun: second byte withheld 37 clocks past its boundary
    base = busy_total;
    do_start();
    fork
      decode_stream(6, LL + 1, 37);
      begin
        wait_cyc(e0 + LL * BCYC);
        put_byte(8'h3C, 1'b0, a0);
        wait_cyc(e0 + (LL + 2) * BCYC + 36);
        chk("C_underrun_set", 32'(underrun), 32'd1);
        put_byte(8'hC3, 1'b1, a1);
        chk("C_late_accept", 32'(a1), 32'(e0 + (LL + 2) * BCYC + 37));
      end
    join
    chk("C_busy_len", 32'(busy_total - base), 32'(6 * BCYC + 37));
    repeat (5) @(negedge clk_sys);
    chk("C_underrun_sticky", 32'(underrun), 32'd1);

    // start pulse and din_valid during leader
    base = busy_total;
    do_start();
    fork
      decode_stream(5, -1, 0);
      begin
        chk("D_underrun_cleared", 32'(underrun), 32'd0);
        put_byte(8'h81, 1'b1, a0);
        chk("D_first_accept", 32'(a0), 32'(e0 + LL * BCYC + 1));
      end
      begin
        wait_cyc(e0 + 40);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
      end
    join
    chk("D_busy_len", 32'(busy_total - base), 32'd320);
    repeat (5) @(negedge clk_sys);

    // reset mid-data with a full hold register
    do_start();
    wait_cyc(e0 + LL * BCYC);
    put_byte(8'h11, 1'b0, a0);
    put_byte(8'h22, 1'b0, a1);
    wait_cyc(e0 + (LL + 1) * BCYC + 8);
    chk("E_busy_before", 32'(busy), 32'd1);
    RESET = 1'b0;
    @(negedge clk_sys);
    RESET = 1'b1;
    chk("E_tape", 32'(tape_out), 32'd0);
    chk("E_busy", 32'(busy), 32'd0);
    chk("E_ready", 32'(bus.din_ready), 32'd0);
    chk("E_underrun", 32'(underrun), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    base = busy_total;
    do_start();
    fork
      decode_stream(5, -1, 0);
      begin wait_cyc(e0 + LL * BCYC); put_byte(8'h5A, 1'b1, a0); end
    join
    chk("E_busy_len", 32'(busy_total - base), 32'd320);
    chk("E_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
